uart_tx_fifo: RTL
=================

# uart_tx_fifo

Byte-wide transmit FIFO sitting between the CPU bus decode (TX data register at 0x8060) and the UART transmitter. It accepts one-cycle write pulses from the bus side, buffers up to 2^DEPTH_LOG2 bytes, and launches them one at a time into the UART using a start-pulse / busy handshake. Software polls fill status through the UART status register instead of spinning on transmitter busy before every byte.

## Interface
- DEPTH_LOG2, 4: log2 of FIFO depth; depth = 16 by default.
- GUARD, 15: maximum cycles to wait for `tx_busy` to rise after a launch before giving up.

- sys_clk  in  1  system clock; all state is updated on the rising edge.
- sys_reset  in  1  synchronous, active-high reset.
- wr_en  in  1  push strobe, one cycle per byte (bus TX write with byte strobe 0).
- wr_data  in  8  byte to push.
- ovf_clr  in  1  clears the sticky overflow flag.
- tx_busy  in  1  UART transmitter busy, from the UART status.
- tx_data  out  8  byte presented to the UART; registered.
- tx_start  out  1  one-cycle launch pulse to the UART; registered.
- full  out  1  level == depth.
- empty  out  1  level == 0.
- level  out  DEPTH_LOG2+1  number of stored bytes.
- overflow  out  1  sticky flag: a write was dropped because the FIFO was full.

## Operation
- Storage is a circular buffer with DEPTH_LOG2-bit read and write pointers. Both pointers wrap modulo depth. `level` is an explicit counter.
- **Push:** when `wr_en` is high and `full` is low at the edge, store `wr_data` at the write pointer and increment the pointer.
  - A push while `full` is dropped. This holds even if a pop occurs on the same edge, because `full` is evaluated from the pre-edge state.
- **Launch FSM** (states IDLE, WAIT_BUSY, WAIT_DONE):
  - IDLE: if `!empty && !tx_busy`, then on the edge:
    - load `tx_data` from the read pointer,
    - set `tx_start` = 1,
    - increment the read pointer,
    - clear the guard counter,
    - go to WAIT_BUSY.
  - WAIT_BUSY: `tx_start` returns to 0 (the pulse lasts exactly one cycle).
    - If `tx_busy` is high, go to WAIT_DONE.
    - Otherwise increment the guard counter; when it reaches GUARD, go to IDLE.
  - WAIT_DONE: when `tx_busy` goes low, go to IDLE.
- At most one byte is in flight. No new launch happens until the FSM is back in IDLE with `tx_busy` low.
- **Simultaneous push and pop:** `level` is unchanged. If `empty` is high, no pop occurs, so a push into an empty FIFO cannot be popped on the same edge.
- `tx_data` holds the last launched byte between launches.

## Timing
- Reset values:
  - `tx_data` = 0, `tx_start` = 0, `full` = 0, `empty` = 1, `level` = 0, `overflow` = 0.
  - Pointers = 0, guard counter = 0, FSM = IDLE.
- Reset mid-operation discards all FIFO contents and any in-flight state. `tx_start` is 0 in the cycle after the reset edge.
- Push latency: `level`, `empty` and `full` reflect a push in the cycle after the `wr_en` edge.
- First-byte latency: `wr_en` at edge N into an empty FIFO in IDLE with `tx_busy` low gives `tx_start` = 1 during the cycle after edge N+1.
- Back-to-back launches: earliest next `tx_start` comes two edges after `tx_busy` falls (WAIT_DONE→IDLE, then IDLE launch).
- Guard timeout: with `tx_busy` stuck low after a launch, the FSM returns to IDLE GUARD+1 edges after the launch edge. The next byte launches on the following edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `UART_TX_FIFO_OVF_FLAG_EN` defined:
  - `overflow` sets on any dropped push and stays set until `ovf_clr`.
  - If `ovf_clr` and a dropped push occur on the same edge, set wins.
- Not defined:
  - `overflow` is tied to 0 and `ovf_clr` is ignored.
  - Dropped pushes are silent. All other behaviour is identical.

## Test plan
- Reset: assert `sys_reset` for 2 cycles mid-traffic → `empty` = 1, `level` = 0, `tx_start` = 0, `tx_data` = 0x00, `overflow` = 0.
- Single byte: push 0x41 at edge N with `tx_busy` = 0 → `tx_start` is a one-cycle pulse after edge N+1 and `tx_data` = 0x41. Bench raises `tx_busy` 3 cycles later for 20 cycles; no second pulse occurs until busy falls.
- Fill and overflow: hold `tx_busy` = 1 and push 0x00..0x0F → `full` = 1, `level` = 16. Push 0xFF → dropped, `overflow` = 1 (macro on) or 0 (macro off). Release busy and emulate the UART → bytes appear in order 0x00..0x0F and 0xFF never appears.
- Guard timeout: push 0x55 and 0x66 with `tx_busy` held 0 → 0x55 launches, the FSM returns to IDLE after GUARD+1 = 16 edges, then 0x66 launches on the next edge.
- Simultaneous push/pop: with `level` = 1 and the FSM in IDLE, push 0x77 on the launch edge → `level` stays 1 and 0x77 is the next byte launched.
- Reset in WAIT_DONE with 3 bytes queued → after reset `level` = 0 and no `tx_start` occurs when `tx_busy` later falls.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte-wide transmit FIFO feeding a UART through a start-pulse / busy handshake.
// Optional sticky overflow flag: define UART_TX_FIFO_OVF_FLAG_EN.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned GUARD      = 15
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  ovf_clr,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int unsigned Depth  = 2 ** DEPTH_LOG2;
  localparam int unsigned GuardW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
  localparam logic [DEPTH_LOG2:0] LevelFull = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [GuardW-1:0]   GuardMax  = GuardW'(GUARD);

  typedef enum logic [1:0] {
    StIdle,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [GuardW-1:0]     guard_q, guard_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  ovf_q, ovf_d;
  logic                  push, pop;

  // Status flags come straight from the level register, so they stay registered.
  assign full     = (level_q == LevelFull);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign overflow = ovf_q;

  assign push = wr_en && !full;
  assign pop  = (state_q == StIdle) && !empty && !tx_busy;

  always_comb begin
    state_d    = state_q;
    guard_d    = guard_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    rd_ptr_d   = rd_ptr_q;
    case (state_q)
      StIdle: begin
        if (pop) begin
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          guard_d    = '0;
          state_d    = StWaitBusy;
        end
      end
      StWaitBusy: begin
        // Give up if the UART never acknowledges, so the queue cannot stall.
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (guard_q == GuardMax) begin
          state_d = StIdle;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

`ifdef UART_TX_FIFO_OVF_FLAG_EN
  // A drop on the same edge as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && full) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_d          = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      guard_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      guard_q    <= guard_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule
